ecall_ctrl: RTL and testbench
=============================

ECALL_CTRL -- requirements
Module: ecall_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20'd500000: cycles confirm must hold stable before acceptance (used only with ECALL_DEBOUNCE_EN).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low; clock clk.
REQ-004 SHALL have port ecall_valid  input  1  decoded ECALL in the current instruction.
REQ-005 SHALL have port a7_value  input  32  service code (register a7 read data).
REQ-006 SHALL have port a0_value  input  32  argument (register a0 read data).
REQ-007 SHALL have port switch  input  8  board switches.
REQ-008 SHALL have port keyboard  input  32  keypad value.
REQ-009 SHALL have port confirm  input  1  user confirm button, asynchronous level.
REQ-010 SHALL have port stop_flag  output  1  pipeline/register-file stall.
REQ-011 SHALL have port wb_en  output  1  register-file write request.
REQ-012 SHALL have port wb_reg  output  5  write target; constant 5'd10 (a0).
REQ-013 SHALL have port wb_data  output  32  write data.
REQ-014 SHALL have port disp_data  output  32  latched print value.
REQ-015 SHALL have port disp_valid  output  1  one-cycle print strobe.
REQ-016 SHALL have port halted  output  1  sticky program-exit flag.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_PRESS, WAIT_RELEASE, WRITE, HALT.
REQ-018 SHALL pass confirm through a 2-flop synchronizer; all FSM decisions use the synchronized level (confirm_s).
REQ-019 IDLE, ecall_valid, a7=1: SHALL load disp_data<=a0_value and pulse disp_valid for exactly the next cycle; no stall; stay IDLE.
REQ-020 IDLE, ecall_valid, a7=5 or a7=12: SHALL go to WAIT_PRESS; a7=10: SHALL go to HALT; any other a7: SHALL be ignored, no stall.
REQ-021 stop_flag SHALL be combinational: 1 in WAIT_PRESS, WAIT_RELEASE, HALT, and in IDLE when ecall_valid with a7 in {5,10,12}; 0 otherwise, including WRITE.
REQ-022 WAIT_PRESS, confirm_s=1: SHALL capture wb_data<=keyboard (a7=5) or {24'b0,switch} (a7=12), service code latched at IDLE exit; go to WAIT_RELEASE.
REQ-023 WAIT_RELEASE, confirm_s=0: SHALL go to WRITE; captured data SHALL NOT change while waiting.
REQ-024 WRITE SHALL last exactly one cycle with wb_en=1, stop_flag=0, ecall_valid ignored (the stalled ECALL retires), then return to IDLE.
REQ-025 wb_en SHALL be 1 only in WRITE; total latency from release seen on confirm_s to wb_en SHALL be 1 cycle.
REQ-026 HALT SHALL be terminal until reset; halted=1; all inputs ignored.
REQ-027 confirm held high when entering WAIT_PRESS SHALL be accepted immediately (level-sensitive).

Reset
REQ-028 Reset low SHALL asynchronously force IDLE, synchronizer and debounce state 0, wb_data=0, disp_data=0, disp_valid=0, halted=0, wb_en=0.
REQ-029 Reset asserted mid-wait (WAIT_PRESS/WAIT_RELEASE) SHALL discard captured data and issue no write.

Configuration
REQ-030 With ECALL_DEBOUNCE_EN defined, confirm_s SHALL change only after the synchronized raw input differs from it for DEBOUNCE_CYCLES consecutive cycles; counter restarts on any bounce.
REQ-031 Without ECALL_DEBOUNCE_EN, confirm_s SHALL equal the 2-flop synchronizer output (2-cycle latency) and no counter SHALL exist.

Verification
REQ-032 a7=1, a0=32'h0000_1234, ecall_valid 1 cycle -> disp_data=32'h1234, disp_valid high exactly 1 cycle, stop_flag never 1.
REQ-033 a7=5, keyboard=32'd77, confirm pulse 5 cycles (no debounce) -> stop_flag high until WRITE; single wb_en cycle, wb_reg=10, wb_data=77.
REQ-034 a7=12, switch=8'hA5, keyboard changed to 99 during WAIT_RELEASE -> wb_data=32'h0000_00A5.
REQ-035 a7=10 -> halted=1, stop_flag=1 held; further ecall_valid/confirm no effect; reset clears both.
REQ-036 a7=5, reset pulsed low in WAIT_RELEASE -> wb_en never 1, all outputs 0, state IDLE.
REQ-037 ECALL_DEBOUNCE_EN, DEBOUNCE_CYCLES=4, confirm glitch 2 cycles then stable 6 -> only the stable press accepted, one write.

Source files
------------

// File: rtl/ecall_ctrl.sv
// ecall_ctrl: ECALL service controller.
// Services: a7=1 print a0, a7=5 read keypad into a0, a7=12 read switches into a0, a7=10 exit.
// Reads stall the pipeline until the user presses and then releases confirm.
// The captured value is written to a0 in a single write cycle after the release.
// Optional build macro ECALL_DEBOUNCE_EN adds a stability filter of DEBOUNCE_CYCLES
// cycles on the synchronized confirm level.
module ecall_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ecall_valid,
  input  logic [31:0] a7_value,
  input  logic [31:0] a0_value,
  input  logic [7:0]  switch,
  input  logic [31:0] keyboard,
  input  logic        confirm,
  output logic        stop_flag,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic        halted
);

  localparam logic [31:0] SvcPrint   = 32'd1;
  localparam logic [31:0] SvcReadKbd = 32'd5;
  localparam logic [31:0] SvcExit    = 32'd10;
  localparam logic [31:0] SvcReadSw  = 32'd12;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPress,
    StWaitRelease,
    StWrite,
    StHalt
  } state_e;

  state_e      r_state;
  logic        r_sel_sw;     // 1: switch read, 0: keypad read; latched when leaving idle
  logic [31:0] r_wb_data;
  logic        r_wb_en;
  logic [31:0] r_disp_data;
  logic        r_disp_valid;
  logic        r_halted;

  logic        r_sync1;
  logic        r_sync2;
  logic        w_confirm_s;

  logic        w_is_print;
  logic        w_is_kbd;
  logic        w_is_sw;
  logic        w_is_exit;

  assign w_is_print = (a7_value == SvcPrint);
  assign w_is_kbd   = (a7_value == SvcReadKbd);
  assign w_is_sw    = (a7_value == SvcReadSw);
  assign w_is_exit  = (a7_value == SvcExit);

  // Two-flop synchronizer for the asynchronous confirm button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= confirm;
      r_sync2 <= r_sync1;
    end
  end

`ifdef ECALL_DEBOUNCE_EN
  logic        r_confirm_s;
  logic [19:0] r_db_cnt;

  // Flip the filtered level only after the raw level has disagreed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_confirm_s <= 1'b0;
      r_db_cnt    <= 20'd0;
    end else if (r_sync2 != r_confirm_s) begin
      if (r_db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
        r_confirm_s <= r_sync2;
        r_db_cnt    <= 20'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 20'd1;
      end
    end else begin
      r_db_cnt <= 20'd0;
    end
  end

  assign w_confirm_s = r_confirm_s;
`else
  logic w_unused_debounce;

  // Filter disabled: the parameter is intentionally unreferenced by logic.
  assign w_unused_debounce = ^DEBOUNCE_CYCLES;
  assign w_confirm_s       = r_sync2;
`endif

  // Service FSM with registered write, display and halt outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_sel_sw     <= 1'b0;
      r_wb_data    <= 32'd0;
      r_wb_en      <= 1'b0;
      r_disp_data  <= 32'd0;
      r_disp_valid <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_disp_valid <= 1'b0;
      r_wb_en      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (ecall_valid) begin
            if (w_is_print) begin
              r_disp_data  <= a0_value;
              r_disp_valid <= 1'b1;
            end else if (w_is_kbd || w_is_sw) begin
              r_sel_sw <= w_is_sw;
              r_state  <= StWaitPress;
            end else if (w_is_exit) begin
              r_halted <= 1'b1;
              r_state  <= StHalt;
            end
          end
        end
        StWaitPress: begin
          // Level-sensitive: a button already held on entry is accepted at once.
          if (w_confirm_s) begin
            r_wb_data <= r_sel_sw ? {24'd0, switch} : keyboard;
            r_state   <= StWaitRelease;
          end
        end
        StWaitRelease: begin
          if (!w_confirm_s) begin
            r_wb_en <= 1'b1;
            r_state <= StWrite;
          end
        end
        StWrite: begin
          // The stalled ECALL retires this cycle; a still-high ecall_valid is not re-decoded.
          r_state <= StIdle;
        end
        StHalt: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Stall while waiting or halted, and in the idle cycle that starts a stalling service.
  always_comb begin
    stop_flag = 1'b0;
    unique case (r_state)
      StIdle:        stop_flag = ecall_valid && (w_is_kbd || w_is_sw || w_is_exit);
      StWaitPress:   stop_flag = 1'b1;
      StWaitRelease: stop_flag = 1'b1;
      StWrite:       stop_flag = 1'b0;
      StHalt:        stop_flag = 1'b1;
      default:       stop_flag = 1'b0;
    endcase
  end

  assign wb_en      = r_wb_en;
  assign wb_reg     = 5'd10;
  assign wb_data    = r_wb_data;
  assign disp_data  = r_disp_data;
  assign disp_valid = r_disp_valid;
  assign halted     = r_halted;

endmodule

// File: tb/tb_ecall_ctrl.sv
// Self-checking bench for ecall_ctrl: table-driven service vectors plus hand-written
// sequences for halt, held confirm, reset during a wait and (with ECALL_DEBOUNCE_EN) debounce.
module tb_ecall_ctrl;

  logic        clk;
  logic        reset;
  logic        ecall_valid;
  logic [31:0] a7_value;
  logic [31:0] a0_value;
  logic [7:0]  switch;
  logic [31:0] keyboard;
  logic        confirm;
  logic        stop_flag;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  ecall_ctrl #(
    .DEBOUNCE_CYCLES(20'd4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ecall_valid(ecall_valid),
    .a7_value   (a7_value),
    .a0_value   (a0_value),
    .switch     (switch),
    .keyboard   (keyboard),
    .confirm    (confirm),
    .stop_flag  (stop_flag),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a7;
    logic [31:0] a0;
    logic [31:0] kb;
    logic [31:0] kb_late;   // keypad value from cycle 6 on (after capture)
    logic [7:0]  sw;
    bit          press;     // raw confirm high for cycles 2..6
    int          exp_stop;  // cycles with stop_flag high
    int          exp_dv;    // cycles with disp_valid high
    int          exp_wb;    // cycles with wb_en high
    int          exp_wb_cyc;
    logic [31:0] exp_wb_data;
    logic [31:0] exp_disp;
  } vec_t;

  vec_t vecs[7];

  // One service request: ecall in cycle 0, optional press/release, 25 observed cycles.
  task automatic run_vec(input int idx, input vec_t v);
    int stop_n = 0;
    int dv_n = 0;
    int wb_n = 0;
    int wb_cyc = -1;
    int bad_write = 0;
    logic [31:0] wbd = 32'd0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      ecall_valid = (k == 0);
      a7_value    = v.a7;
      a0_value    = v.a0;
      switch      = v.sw;
      keyboard    = (k >= 6) ? v.kb_late : v.kb;
      confirm     = v.press && (k >= 2) && (k < 7);
      #1;
      if (stop_flag) stop_n++;
      if (disp_valid) dv_n++;
      if (wb_en) begin
        wb_n++;
        wb_cyc = k;
        wbd = wb_data;
        if (stop_flag || wb_reg != 5'd10) bad_write++;
      end
    end
    chk($sformatf("v%0d stop_cycles", idx), stop_n, v.exp_stop);
    chk($sformatf("v%0d disp_valid_cycles", idx), dv_n, v.exp_dv);
    chk($sformatf("v%0d wb_count", idx), wb_n, v.exp_wb);
    chk($sformatf("v%0d wb_cycle", idx), wb_cyc, v.exp_wb_cyc);
    chk($sformatf("v%0d disp_data", idx), disp_data, v.exp_disp);
    chk($sformatf("v%0d write_cycle_stop_or_reg", idx), bad_write, 0);
    if (v.exp_wb != 0) chk($sformatf("v%0d wb_data", idx), wbd, v.exp_wb_data);
  endtask

  initial begin
    int stop_n;
    int dv_n;
    int wb_n;
    int wb_cyc;
    logic [31:0] wbd;

    reset       = 1'b0;
    ecall_valid = 1'b0;
    a7_value    = 32'd0;
    a0_value    = 32'd0;
    switch      = 8'd0;
    keyboard    = 32'd0;
    confirm     = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset stop_flag", stop_flag, 0);
    chk("reset wb_en", wb_en, 0);
    chk("reset wb_data", wb_data, 0);
    chk("reset disp_data", disp_data, 0);
    chk("reset disp_valid", disp_valid, 0);
    chk("reset halted", halted, 0);
    chk("reset wb_reg", wb_reg, 10);
    @(negedge clk);
    reset = 1'b1;

`ifdef ECALL_DEBOUNCE_EN
    // Glitch of 2 cycles must be rejected; the 6-cycle press is the only accepted one.
    stop_n = 0;
    wb_n = 0;
    wb_cyc = -1;
    wbd = 32'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ecall_valid = (k == 0);
      a7_value    = 32'd5;
      keyboard    = 32'h3C;
      confirm     = (k >= 3 && k < 5) || (k >= 8 && k < 14);
      #1;
      if (stop_flag) stop_n++;
      if (wb_en) begin
        wb_n++;
        wb_cyc = k;
        wbd = wb_data;
      end
    end
    chk("debounce wb_count", wb_n, 1);
    chk("debounce wb_cycle", wb_cyc, 21);
    chk("debounce wb_data", wbd, 32'h3C);
    chk("debounce stop_cycles", stop_n, 21);
`else
    //          a7        a0             kb             kb_late   sw     press stop dv wb cyc wbdata        disp
    vecs[0] = '{32'd1,    32'h0000_1234, 32'd0,         32'd0,    8'h00, 1'b0, 0,   1, 0, -1, 32'd0,        32'h1234};
    vecs[1] = '{32'd5,    32'd0,         32'd77,        32'd77,   8'h00, 1'b1, 10,  0, 1, 10, 32'd77,       32'h1234};
    vecs[2] = '{32'd12,   32'd0,         32'd5,         32'd99,   8'hA5, 1'b1, 10,  0, 1, 10, 32'h0000_00A5, 32'h1234};
    vecs[3] = '{32'd5,    32'd0,         32'hDEAD_BEEF, 32'd0,    8'hFF, 1'b1, 10,  0, 1, 10, 32'hDEAD_BEEF, 32'h1234};
    vecs[4] = '{32'd3,    32'h5555_5555, 32'd1,         32'd1,    8'h01, 1'b1, 0,   0, 0, -1, 32'd0,        32'h1234};
    vecs[5] = '{32'd1,    32'hCAFE_F00D, 32'd0,         32'd0,    8'h00, 1'b1, 0,   1, 0, -1, 32'd0,        32'hCAFE_F00D};
    vecs[6] = '{32'h105,  32'h1111_1111, 32'd2,         32'd2,    8'h02, 1'b1, 0,   0, 0, -1, 32'd0,        32'hCAFE_F00D};
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Confirm already held when the read starts is accepted immediately.
    confirm = 1'b1;
    repeat (4) @(negedge clk);
    stop_n = 0;
    wb_n = 0;
    wb_cyc = -1;
    wbd = 32'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ecall_valid = (k == 0);
      a7_value    = 32'd5;
      keyboard    = 32'h55;
      confirm     = (k < 3);
      #1;
      if (stop_flag) stop_n++;
      if (wb_en) begin
        wb_n++;
        wb_cyc = k;
        wbd = wb_data;
      end
    end
    chk("held wb_cycle", wb_cyc, 6);
    chk("held wb_count", wb_n, 1);
    chk("held wb_data", wbd, 32'h55);
    chk("held stop_cycles", stop_n, 6);

    // Reset during the release wait discards the capture and issues no write.
    wb_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ecall_valid = (k == 0);
      a7_value    = 32'd5;
      keyboard    = 32'h77;
      confirm     = (k >= 2) && (k < 12);
      if (k == 7) begin
        #1;
        chk("midwait stall before reset", stop_flag, 1);
        chk("midwait captured before reset", wb_data, 32'h77);
        reset = 1'b0;
        #2;
        chk("midwait rst wb_data", wb_data, 0);
        chk("midwait rst stop_flag", stop_flag, 0);
        chk("midwait rst disp_data", disp_data, 0);
        chk("midwait rst halted", halted, 0);
      end
      if (k == 8) reset = 1'b1;
      #1;
      if (wb_en) wb_n++;
    end
    chk("midwait wb_count", wb_n, 0);
    chk("midwait idle stop_flag", stop_flag, 0);
    @(negedge clk);
    ecall_valid = 1'b1;
    a7_value    = 32'd1;
    a0_value    = 32'h0ABC;
    @(negedge clk);
    ecall_valid = 1'b0;
    #1;
    chk("midwait idle print valid", disp_valid, 1);
    chk("midwait idle print data", disp_data, 32'h0ABC);

    // Exit is terminal: stall held, other services and confirm have no effect until reset.
    @(negedge clk);
    ecall_valid = 1'b1;
    a7_value    = 32'd10;
    #1;
    chk("exit stop_flag comb", stop_flag, 1);
    stop_n = 0;
    dv_n = 0;
    wb_n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ecall_valid = k[0];
      a7_value    = k[1] ? 32'd1 : 32'd5;
      a0_value    = 32'hFFFF_FFFF;
      confirm     = k[2];
      #1;
      if (stop_flag) stop_n++;
      if (disp_valid) dv_n++;
      if (wb_en) wb_n++;
      if (k == 11) chk("halt halted", halted, 1);
    end
    chk("halt stop_cycles", stop_n, 12);
    chk("halt disp_valid_cycles", dv_n, 0);
    chk("halt wb_count", wb_n, 0);
    chk("halt disp_data held", disp_data, 32'h0ABC);
    ecall_valid = 1'b0;
    reset = 1'b0;
    #2;
    chk("halt rst halted", halted, 0);
    chk("halt rst stop_flag", stop_flag, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("after halt reset halted", halted, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
